// File: rtl/pk_poci.sv
// POCI bus shared types and peripheral address map.
// Used by bus initiators, slaves and the interface.
package pk_poci;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

  localparam addr_t KEYS_ADDR = 32'h0000_1000;
  localparam addr_t LED_ADDR  = 32'h0000_1004;

endpackage

// File: rtl/if_poci.sv
// POCI bus signal bundle.
// Initiator drives the request side, slave returns data and status.
interface if_poci;
  import pk_poci::*;

  addr_t paddr;
  logic  pwrite;
  logic  psel;
  logic  penable;
  data_t pwdata;
  data_t prdata;
  logic  pready;
  logic  pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/poci_master.sv
// POCI initiator: one request in, one setup/access transfer out,
// one response back; a watchdog aborts transfers stuck in ACCESS.
module poci_master
  import pk_poci::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  req_valid,
  output logic  req_ready,
  input  logic  req_write,
  input  addr_t req_addr,
  input  data_t req_wdata,
  output logic  rsp_valid,
  input  logic  rsp_ready,
  output data_t rsp_rdata,
  output logic  rsp_err,
  output logic  rsp_timeout,
  if_poci.master bus
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  localparam logic WDOG_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, RESP
  } state_e;

  state_e        state_q, state_d;
  addr_t         paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  data_t         pwdata_q, pwdata_d;
  data_t         rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State, captured request and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: accept, setup, wait for pready or watchdog, respond.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_write ? req_wdata : '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rdata_d = pwrite_q ? '0 : bus.prdata;
          err_d   = bus.pslverr;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (WDOG_EN && cnt_q == TMO) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

  assign bus.psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable = (state_q == ACCESS);
  assign bus.paddr   = paddr_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.pwdata  = pwdata_q;

endmodule

// File: tb/tb_poci_master.sv
// Bench for poci_master: directed transfers, then random ones
// checked against a cycle-count/response model of the transfer rules.
module tb_poci_master;
  import pk_poci::*;

  localparam int TMO = 4;

  logic  clk = 1'b0;
  logic  reset;
  logic  req_valid, req_ready, req_write;
  addr_t req_addr;
  data_t req_wdata;
  logic  rsp_valid, rsp_ready;
  data_t rsp_rdata;
  logic  rsp_err, rsp_timeout;

  if_poci bus_if();

  int    tests = 0;
  int    fails = 0;
  int    wait_cfg = 0;
  data_t cfg_rdata = '0;
  logic  cfg_err = 1'b0;
  int    acc_cnt;

  poci_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Slave: raises pready after wait_cfg access cycles.
  always @(posedge clk or posedge reset)
    if (reset) acc_cnt <= 0;
    else if (bus_if.psel && bus_if.penable) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;

  assign bus_if.pready  = bus_if.psel && bus_if.penable &&
                          (acc_cnt == wait_cfg);
  assign bus_if.prdata  = cfg_rdata;
  assign bus_if.pslverr = cfg_err;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transfer; w = slave wait states, hold = cycles rsp_ready low.
  task automatic xfer(input logic wr, input addr_t a, input data_t wd,
                      input int w, input data_t rd, input logic se,
                      input int hold);
    int    lat;
    int    exp_lat;
    logic  exp_to;
    data_t exp_rd;
    data_t exp_wd;
    logic  exp_err;
    logic  bus_ok;
    exp_to  = (w > TMO);
    exp_lat = exp_to ? TMO + 3 : w + 3;
    exp_rd  = (wr || exp_to) ? '0 : rd;
    exp_err = exp_to || se;
    exp_wd  = wr ? wd : '0;
    wait_cfg  = w;
    cfg_rdata = rd;
    cfg_err   = se;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = addr_t'($urandom);
    req_wdata = data_t'($urandom);
    lat = 0;
    bus_ok = 1'b1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      if (lat == 1) begin
        chk("setup_psel", 32'(bus_if.psel), 32'd1);
        chk("setup_penable", 32'(bus_if.penable), 32'd0);
        chk("setup_pwdata", bus_if.pwdata, exp_wd);
      end
      if (lat == 2)
        chk("access_penable", 32'(bus_if.penable), 32'd1);
      if (!(bus_if.psel === 1'b1 && bus_if.paddr === a &&
            bus_if.pwrite === wr && bus_if.pwdata === exp_wd &&
            req_ready === 1'b0))
        bus_ok = 1'b0;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("bus_stable", 32'(bus_ok), 32'd1);
    chk("psel_at_rsp", 32'(bus_if.psel), 32'd0);
    chk("penable_at_rsp", 32'(bus_if.penable), 32'd0);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    req_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_psel", 32'(bus_if.psel), 32'd0);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", 32'(rsp_err), 32'(exp_err));
      chk("hold_timeout", 32'(rsp_timeout), 32'(exp_to));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic seen;
    logic  wr;
    addr_t a;
    int    sel;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_psel", 32'(bus_if.psel), 32'd0);
    chk("rst_penable", 32'(bus_if.penable), 32'd0);
    chk("rst_pwrite", 32'(bus_if.pwrite), 32'd0);
    chk("rst_paddr", bus_if.paddr, 32'd0);
    chk("rst_pwdata", bus_if.pwdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    xfer(1'b1, LED_ADDR, 32'h0000_00A5, 0, 32'hDEAD_BEEF, 1'b0, 0);
    xfer(1'b0, KEYS_ADDR, 32'h0, 3, 32'h1234_5678, 1'b0, 0);
    xfer(1'b0, KEYS_ADDR, 32'h0, 1, 32'h0000_0055, 1'b1, 0);
    xfer(1'b0, LED_ADDR, 32'h0, 1000, 32'hCAFE_F00D, 1'b0, 0);
    xfer(1'b0, LED_ADDR, 32'h0, TMO, 32'h0BAD_CAFE, 1'b0, 0);
    xfer(1'b1, LED_ADDR, 32'h0000_003C, 0, 32'h1111_1111, 1'b0, 5);
    xfer(1'b0, KEYS_ADDR, 32'h0, 2, 32'hA5A5_5A5A, 1'b0, 0);

    // Reset pulsed while the slave holds off in ACCESS.
    wait_cfg = 1000;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = LED_ADDR;
    req_wdata = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_penable", 32'(bus_if.penable), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_psel", 32'(bus_if.psel), 32'd0);
    chk("async_penable", 32'(bus_if.penable), 32'd0);
    chk("async_paddr", bus_if.paddr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_rst", 32'(seen), 32'd0);
    xfer(1'b0, KEYS_ADDR, 32'h0, 1, 32'h0F0F_F0F0, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      wr  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 2);
      a   = (sel == 0) ? KEYS_ADDR :
            (sel == 1) ? LED_ADDR : addr_t'($urandom);
      xfer(wr, a, data_t'($urandom), $urandom_range(0, 6),
           data_t'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
